// File: rtl/dram_cmd_issuer_if.sv
// FIFO-side and DRAM-command-side signals of the command issuer.
// The issuer connects through the slave modport; the driver side uses master.
interface dram_cmd_issuer_if #(
    parameter int ROW_W = 4,
    parameter int COL_W = 3
);
    localparam int REQ_W  = 1 + ROW_W + COL_W;
    localparam int ADDR_W = (ROW_W > COL_W) ? ROW_W : COL_W;

    logic              en;
    logic              fifo_empty;
    logic [REQ_W-1:0]  fifo_dataout;
    logic              fifo_rd_en;
    logic [2:0]        cmd;
    logic [ADDR_W-1:0] cmd_addr;
    logic              busy;
    logic              done;

    modport master (
        output en, fifo_empty, fifo_dataout,
        input  fifo_rd_en, cmd, cmd_addr, busy, done
    );

    modport slave (
        input  en, fifo_empty, fifo_dataout,
        output fifo_rd_en, cmd, cmd_addr, busy, done
    );
endinterface

// File: rtl/dram_cmd_issuer.sv
// Single-bank DRAM command issuer: pops {we,row,col} requests one at a time and
// issues PRE/ACT/RD/WR under an open-row policy with tRP/tRCD/tCL spacing.
module dram_cmd_issuer #(
    parameter int ROW_W = 4,
    parameter int COL_W = 3,
    parameter int T_RP  = 2,
    parameter int T_RCD = 3,
    parameter int T_CL  = 2
)(
    input  logic            clk,
    input  logic            rst_b,
    dram_cmd_issuer_if.slave bus
);
    localparam int REQ_W  = 1 + ROW_W + COL_W;
    localparam int ADDR_W = (ROW_W > COL_W) ? ROW_W : COL_W;
    localparam int T_MAX  = (T_RP > T_RCD) ? ((T_RP > T_CL) ? T_RP : T_CL)
                                           : ((T_RCD > T_CL) ? T_RCD : T_CL);
    localparam int TMR_W  = $clog2(T_MAX) + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_PRE    = 3'd3;
    localparam logic [2:0] S_ACT    = 3'd4;
    localparam logic [2:0] S_RW     = 3'd5;
    localparam logic [2:0] S_WAIT   = 3'd6;

    localparam logic [2:0] C_NOP = 3'b000;
    localparam logic [2:0] C_ACT = 3'b001;
    localparam logic [2:0] C_RD  = 3'b010;
    localparam logic [2:0] C_WR  = 3'b011;
    localparam logic [2:0] C_PRE = 3'b100;

    logic [2:0]        r_state;
    logic [TMR_W-1:0]  r_timer;
    logic              r_we;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic              r_row_open;
    logic [ROW_W-1:0]  r_open_row;
    logic              r_rd_en;
    logic [2:0]        r_cmd;
    logic [ADDR_W-1:0] r_addr;
    logic              r_busy;
    logic              r_done;

    logic              w_we;
    logic [ROW_W-1:0]  w_row;
    logic [COL_W-1:0]  w_col;
    logic              w_hit;

    // Decode straight off the FIFO output so the first command lands in cycle 2.
    assign w_we  = bus.fifo_dataout[REQ_W-1];
    assign w_row = bus.fifo_dataout[COL_W +: ROW_W];
    assign w_col = bus.fifo_dataout[COL_W-1:0];
    assign w_hit = r_row_open && (w_row == r_open_row);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_we       <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
            r_row_open <= 1'b0;
            r_open_row <= '0;
            r_rd_en    <= 1'b0;
            r_cmd      <= C_NOP;
            r_addr     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_rd_en <= 1'b0;
            r_cmd   <= C_NOP;
            r_addr  <= '0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.en && !bus.fifo_empty) begin
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    r_we  <= w_we;
                    r_row <= w_row;
                    r_col <= w_col;
                    if (w_hit) begin
                        r_cmd   <= w_we ? C_WR : C_RD;
                        r_addr  <= ADDR_W'(w_col);
                        r_timer <= TMR_W'(T_CL - 1);
                        r_state <= S_RW;
                    end else if (r_row_open) begin
                        r_cmd      <= C_PRE;
                        r_row_open <= 1'b0;
                        r_timer    <= TMR_W'(T_RP - 1);
                        r_state    <= S_PRE;
                    end else begin
                        r_cmd      <= C_ACT;
                        r_addr     <= ADDR_W'(w_row);
                        r_row_open <= 1'b1;
                        r_open_row <= w_row;
                        r_timer    <= TMR_W'(T_RCD - 1);
                        r_state    <= S_ACT;
                    end
                end
                S_PRE: begin
                    if (r_timer == '0) begin
                        r_cmd      <= C_ACT;
                        r_addr     <= ADDR_W'(r_row);
                        r_row_open <= 1'b1;
                        r_open_row <= r_row;
                        r_timer    <= TMR_W'(T_RCD - 1);
                        r_state    <= S_ACT;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_ACT: begin
                    if (r_timer == '0) begin
                        r_cmd   <= r_we ? C_WR : C_RD;
                        r_addr  <= ADDR_W'(r_col);
                        r_timer <= TMR_W'(T_CL - 1);
                        r_state <= S_RW;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_RW, S_WAIT: begin
                    if (r_timer == '0) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.fifo_rd_en = r_rd_en;
    assign bus.cmd        = r_cmd;
    assign bus.cmd_addr   = r_addr;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_dram_cmd_issuer.sv
// Scoreboard bench for dram_cmd_issuer: a FIFO model feeds requests, a bank model
// predicts command/done timing relative to each pop, and a monitor compares.
module tb_dram_cmd_issuer;
    localparam int ROW_W = 4;
    localparam int COL_W = 3;
    localparam int T_RP  = 2;
    localparam int T_RCD = 3;
    localparam int T_CL  = 2;
    localparam int K_DONE = 8;

    typedef struct {
        int kind;   // command code, or K_DONE
        int addr;
        int off;    // cycles after the pop cycle
    } ev_t;

    logic clk;
    logic rst_b;
    int   checks;
    int   errors;
    int   cyc;
    int   pop_cyc;
    int   outstanding;
    bit   in_rst;
    bit   m_open;
    int   m_row;
    logic [7:0] fq[$];
    ev_t  exp_q[$];

    dram_cmd_issuer_if #(.ROW_W(ROW_W), .COL_W(COL_W)) bus ();

    dram_cmd_issuer #(
        .ROW_W(ROW_W), .COL_W(COL_W), .T_RP(T_RP), .T_RCD(T_RCD), .T_CL(T_CL)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: data appears the cycle after the pop strobe.
    always @(posedge clk) begin
        if (bus.fifo_rd_en && fq.size() != 0)
            bus.fifo_dataout <= fq.pop_front();
    end

    function automatic ev_t mk(input int k, input int a, input int o);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.off  = o;
        return e;
    endfunction

    // Bank model: what a request must produce given which row is open.
    task automatic push_req(input logic [7:0] w);
        int we, row, col, t;
        we  = int'(w[7]);
        row = int'(w[6:3]);
        col = int'(w[2:0]);
        t   = 2;
        if (!(m_open && m_row == row)) begin
            if (m_open) begin
                exp_q.push_back(mk(4, 0, t));
                t += T_RP;
            end
            exp_q.push_back(mk(1, row, t));
            t += T_RCD;
        end
        exp_q.push_back(mk(we != 0 ? 3 : 2, col, t));
        t += T_CL;
        exp_q.push_back(mk(K_DONE, 0, t));
        m_open = 1'b1;
        m_row  = row;
        fq.push_back(w);
    endtask

    task automatic check_ev(input int kind, input int addr);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event_unexpected kind=%0d addr=%0d at offset %0d, none required",
                     kind, addr, cyc - pop_cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.addr != addr || e.off != cyc - pop_cyc) begin
                errors++;
                $display("FAIL event kind/addr/off got %0d/%0d/%0d required %0d/%0d/%0d",
                         kind, addr, cyc - pop_cyc, e.kind, e.addr, e.off);
            end
        end
    endtask

    // Monitor: sampled mid-cycle; also owns the FIFO empty flag.
    always @(negedge clk) begin
        if (in_rst || !rst_b) begin
            outstanding = 0;
        end else begin
            if (bus.fifo_rd_en) begin
                checks++;
                if (outstanding != 0 || fq.size() == 0) begin
                    errors++;
                    $display("FAIL pop_legal outstanding=%0d fifo_entries=%0d required 0 and >0",
                             outstanding, fq.size());
                end
                outstanding = 1;
                pop_cyc     = cyc;
            end
            if (bus.cmd != 3'b000) check_ev(int'(bus.cmd), int'(bus.cmd_addr));
            if (bus.done) begin
                check_ev(K_DONE, 0);
                outstanding = 0;
            end
            checks++;
            if (bus.busy != (outstanding != 0)) begin
                errors++;
                $display("FAIL busy got %0b required %0b", bus.busy, outstanding != 0);
            end
        end
        bus.fifo_empty = (fq.size() == 0);
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fq.size() != 0 || bus.busy) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL idle_timeout pending_events=%0d required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string name);
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (bus.fifo_rd_en || bus.cmd != 3'b000 || bus.busy) begin
                errors++;
                $display("FAIL %s rd_en/cmd/busy got %0b/%0d/%0b required 0/0/0",
                         name, bus.fifo_rd_en, bus.cmd, bus.busy);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outs(input string name);
        checks++;
        if (bus.fifo_rd_en || bus.cmd != 3'b000 || bus.cmd_addr != '0 || bus.busy || bus.done) begin
            errors++;
            $display("FAIL %s rd_en/cmd/addr/busy/done got %0b/%0d/%0d/%0b/%0b required all 0",
                     name, bus.fifo_rd_en, bus.cmd, bus.cmd_addr, bus.busy, bus.done);
        end
    endtask

    initial begin
        int n;
        logic [7:0] w;
        checks = 0; errors = 0; cyc = 0; pop_cyc = 0; outstanding = 0;
        m_open = 1'b0; m_row = 0; in_rst = 1'b1;
        bus.en = 1'b0;
        bus.fifo_dataout = '0;
        rst_b = 1'b1;
        #1 rst_b = 1'b0;
        #1 check_reset_outs("reset_init");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outs("reset_hold");
        rst_b = 1'b1;
        in_rst = 1'b0;
        @(posedge clk);
        #1;

        // Abort a request during the ACT wait.
        bus.en = 1'b1;
        push_req(8'h16);
        n = 0;
        while (bus.cmd != 3'b001 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL act_timeout cmd=%0d required 1", bus.cmd);
        end
        @(posedge clk);
        #2;
        in_rst = 1'b1;
        rst_b  = 1'b0;
        #1 check_reset_outs("reset_async");
        fq.delete();
        exp_q.delete();
        m_open = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        in_rst = 1'b0;
        @(posedge clk);
        #1;

        // Closed bank, row hit, row miss.
        push_req(8'h25);
        wait_idle();
        push_req(8'hA3);
        wait_idle();
        push_req(8'h31);
        wait_idle();

        // en low with a queued request, then en drop mid-request.
        bus.en = 1'b0;
        push_req(8'hB0);
        check_quiet("en_low");
        bus.en = 1'b1;
        n = 0;
        while (!bus.busy && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1 bus.en = 1'b0;
        repeat (12) @(posedge clk);
        #1 bus.en = 1'b1;
        wait_idle();

        // Empty FIFO with en high.
        check_quiet("fifo_empty");

        // Back-to-back hits on the open row.
        push_req(8'h32);
        push_req(8'hB5);
        push_req(8'h37);
        wait_idle();

        // Random traffic on a small row set so hits and misses both occur.
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #1;
            if ($urandom_range(0, 3) == 0) begin
                bus.en = 1'b0;
                repeat ($urandom_range(1, 8)) @(posedge clk);
                #1 bus.en = 1'b1;
            end
            w = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
            if ($urandom_range(0, 7) == 0) w[6:3] = 4'($urandom_range(0, 15));
            push_req(w);
        end
        wait_idle();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_events got %0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
